// File: rtl/gb_audio_lj_receiver.sv
// Left-justified, MSB-first serial audio receiver.
// Oversamples BCLK/LRCK/DAT in the system clock domain and deserialises
// stereo words into parallel left/right samples.
module gb_audio_lj_receiver #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  aud_bclk,
    input  logic                  aud_lrck,
    input  logic                  aud_dat,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_left,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  frame_valid,
    output logic                  short_err
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned ARM_W = SYNC_STAGES + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Synchroniser chains, edge-detect flops and warm-up tracker.
    logic [SYNC_STAGES-1:0] bclk_sr;
    logic [SYNC_STAGES-1:0] lrck_sr;
    logic [SYNC_STAGES-1:0] dat_sr;
    logic                   bclk_q;
    logic                   lrck_q;
    logic [ARM_W-1:0]       arm_sr;

    logic bclk_s;
    logic lrck_s;
    logic dat_s;
    logic armed;
    logic bclk_rise_c;
    logic lr_edge_c;

    // FSM and datapath state.
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  chan_q, chan_d;
    logic                  pair_q, pair_d;

    // Next values for registered outputs.
    logic [DATA_WIDTH-1:0] word_data_d;
    logic                  word_left_d;
    logic                  word_valid_d;
    logic [DATA_WIDTH-1:0] left_sample_d;
    logic [DATA_WIDTH-1:0] right_sample_d;
    logic                  frame_valid_d;
    logic                  short_err_d;

    logic [DATA_WIDTH-1:0] shift_in_c;
    logic                  commit_c;
    logic                  short_c;

    // Synchronise the serial pins and hold events off until the chain is primed,
    // so a pin already high at reset release does not look like an edge.
    always_ff @(posedge clock) begin
        if (rst) begin
            bclk_sr <= '0;
            lrck_sr <= '0;
            dat_sr  <= '0;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            arm_sr  <= '0;
        end else begin
            bclk_sr <= {bclk_sr[SYNC_STAGES-2:0], aud_bclk};
            lrck_sr <= {lrck_sr[SYNC_STAGES-2:0], aud_lrck};
            dat_sr  <= {dat_sr[SYNC_STAGES-2:0], aud_dat};
            bclk_q  <= bclk_sr[SYNC_STAGES-1];
            lrck_q  <= lrck_sr[SYNC_STAGES-1];
            arm_sr  <= {arm_sr[ARM_W-2:0], 1'b1};
        end
    end

    assign bclk_s      = bclk_sr[SYNC_STAGES-1];
    assign lrck_s      = lrck_sr[SYNC_STAGES-1];
    assign dat_s       = dat_sr[SYNC_STAGES-1];
    assign armed       = arm_sr[ARM_W-1];
    assign bclk_rise_c = armed & bclk_s & ~bclk_q;
    assign lr_edge_c   = armed & (lrck_s ^ lrck_q);
    assign shift_in_c  = {shift_q[DATA_WIDTH-2:0], dat_s};

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            count_q      <= '0;
            chan_q       <= 1'b0;
            pair_q       <= 1'b0;
            word_data    <= '0;
            word_left    <= 1'b0;
            word_valid   <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            frame_valid  <= 1'b0;
            short_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            chan_q       <= chan_d;
            pair_q       <= pair_d;
            word_data    <= word_data_d;
            word_left    <= word_left_d;
            word_valid   <= word_valid_d;
            left_sample  <= left_sample_d;
            right_sample <= right_sample_d;
            frame_valid  <= frame_valid_d;
            short_err    <= short_err_d;
        end
    end

    // Next-state logic: an LRCK edge always restarts a word and takes priority
    // over a coincident BCLK rise, which then supplies the new word's MSB.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        count_d  = count_q;
        chan_d   = chan_q;
        commit_c = 1'b0;
        short_c  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (lr_edge_c) begin
                    state_d = SHIFT;
                    chan_d  = lrck_s;
                    count_d = bclk_rise_c ? CNT_W'(1) : CNT_W'(0);
                    if (bclk_rise_c) begin
                        shift_d = shift_in_c;
                    end
                end
            end
            SHIFT: begin
                if (lr_edge_c) begin
                    short_c = 1'b1;
                    chan_d  = lrck_s;
                    count_d = bclk_rise_c ? CNT_W'(1) : CNT_W'(0);
                    if (bclk_rise_c) begin
                        shift_d = shift_in_c;
                    end
                end else if (bclk_rise_c) begin
                    shift_d = shift_in_c;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                        commit_c = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values: commit publishes the word and tracks left/right pairing.
    always_comb begin
        word_data_d    = word_data;
        word_left_d    = word_left;
        word_valid_d   = commit_c;
        left_sample_d  = left_sample;
        right_sample_d = right_sample;
        frame_valid_d  = commit_c & ~chan_q & pair_q;
        pair_d         = pair_q;
        short_err_d    = short_err;

        if (commit_c) begin
            word_data_d = shift_in_c;
            word_left_d = chan_q;
            pair_d      = chan_q;
            if (chan_q) begin
                left_sample_d = shift_in_c;
            end else begin
                right_sample_d = shift_in_c;
            end
        end

        if (short_c) begin
            short_err_d = 1'b1;
        end else if (err_clr) begin
            short_err_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_gb_audio_lj_receiver.sv
// Bench for gb_audio_lj_receiver: serial LJ transmitter, scoreboard and monitor.
module tb_gb_audio_lj_receiver;

    logic        clock;
    logic        rst;
    logic        aud_bclk;
    logic        aud_lrck;
    logic        aud_dat;
    logic        err_clr;
    logic [15:0] word_data;
    logic        word_left;
    logic        word_valid;
    logic [15:0] left_sample;
    logic [15:0] right_sample;
    logic        frame_valid;
    logic        short_err;

    gb_audio_lj_receiver #(
        .DATA_WIDTH (16),
        .SYNC_STAGES(2)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .aud_bclk    (aud_bclk),
        .aud_lrck    (aud_lrck),
        .aud_dat     (aud_dat),
        .err_clr     (err_clr),
        .word_data   (word_data),
        .word_left   (word_left),
        .word_valid  (word_valid),
        .left_sample (left_sample),
        .right_sample(right_sample),
        .frame_valid (frame_valid),
        .short_err   (short_err)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        left;
        logic        frame;
        logic [15:0] ls;
        logic [15:0] rs;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what a listener expects from the link.
    bit          m_lr         = 1'b0;
    bit          m_pair       = 1'b0;
    bit          m_pend_short = 1'b0;
    bit          m_short      = 1'b0;
    logic [15:0] m_ls         = 16'h0;
    logic [15:0] m_rs         = 16'h0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word_valid pops one expected word.
    always @(negedge clock) begin
        exp_t e;
        if (word_valid) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %h left=%0d expected none", word_data, word_left);
            end else begin
                e = sb_q.pop_front();
                check("word_data", 32'(word_data), 32'(e.data));
                check("word_left", 32'(word_left), 32'(e.left));
                check("frame_valid", 32'(frame_valid), 32'(e.frame));
                check("left_sample", 32'(left_sample), 32'(e.ls));
                check("right_sample", 32'(right_sample), 32'(e.rs));
            end
        end else if (frame_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_frame_valid: got 1 expected 0 at %0t", $time);
        end
    end

    // Send one channel slot: nbits BCLKs, top 16 carry w MSB-first, rest random padding.
    // coinc puts the LRCK edge on the first BCLK rise; rst_at>0 pulses reset after that many bits.
    task automatic send_chunk(input bit lr, input int nbits, input logic [15:0] w,
                              input bit coinc, input int rst_at);
        bit          is_edge;
        logic [15:0] sh;
        exp_t        e;
        is_edge = (lr != m_lr);
        if (rst_at > 0) begin
            m_pair       = 1'b0;
            m_ls         = 16'h0;
            m_rs         = 16'h0;
            m_short      = 1'b0;
            m_pend_short = 1'b0;
        end else if (is_edge) begin
            if (m_pend_short) m_short = 1'b1;
            m_pend_short = 1'b0;
            if (nbits >= 16) begin
                e.data  = w;
                e.left  = lr;
                e.frame = !lr && m_pair;
                if (lr) begin
                    m_ls   = w;
                    m_pair = 1'b1;
                end else begin
                    m_rs   = w;
                    m_pair = 1'b0;
                end
                e.ls = m_ls;
                e.rs = m_rs;
                sb_q.push_back(e);
            end else begin
                m_pend_short = 1'b1;
            end
        end
        m_lr = lr;

        sh = w;
        for (int i = 0; i < nbits; i++) begin
            aud_dat = (i < 16) ? sh[15] : 1'($urandom);
            sh      = sh << 1;
            if (i == 0 && coinc) begin
                #20;
                aud_lrck = lr;
                aud_bclk = 1'b1;
                #40;
                aud_bclk = 1'b0;
                #20;
            end else begin
                if (i == 0) aud_lrck = lr;
                #40;
                aud_bclk = 1'b1;
                #40;
                aud_bclk = 1'b0;
            end
            if (rst_at > 0 && i == rst_at - 1) begin
                rst = 1'b1;
                #30;
                rst = 1'b0;
            end
        end
        check("short_err", 32'(short_err), 32'(m_short));
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        #10;
        err_clr = 1'b0;
        m_short = 1'b0;
        #10;
        check("short_err_clr", 32'(short_err), 32'(m_short));
    endtask

    // Watchdog: never hang.
    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int          nb;
        bit          lr;
        logic [15:0] l_w;
        rst      = 1'b1;
        aud_bclk = 1'b0;
        aud_lrck = 1'b0;
        aud_dat  = 1'b0;
        err_clr  = 1'b0;
        #103;
        rst = 1'b0;
        #50;
        check("rst_word_data", 32'(word_data), 32'h0);
        check("rst_word_left", 32'(word_left), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_left_sample", 32'(left_sample), 32'h0);
        check("rst_right_sample", 32'(right_sample), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_short_err", 32'(short_err), 32'h0);

        // Preamble without an LRCK edge: nothing may be emitted.
        send_chunk(1'b0, 8, 16'hFFFF, 1'b0, 0);

        // Basic pair.
        send_chunk(1'b1, 16, 16'hA5C3, 1'b0, 0);
        send_chunk(1'b0, 16, 16'h1234, 1'b0, 0);

        // 32-BCLK slots with random padding.
        send_chunk(1'b1, 32, 16'hBEEF, 1'b0, 0);
        send_chunk(1'b0, 32, 16'h0F0F, 1'b0, 0);

        // Short word then recovery and clear.
        send_chunk(1'b1, 10, 16'hDEAD, 1'b0, 0);
        send_chunk(1'b0, 16, 16'h5A5A, 1'b0, 0);
        pulse_clr();
        send_chunk(1'b1, 16, 16'hC001, 1'b0, 0);

        // LRCK edge coincident with BCLK rise.
        send_chunk(1'b0, 16, 16'h8001, 1'b1, 0);
        send_chunk(1'b1, 16, 16'hFFFE, 1'b1, 0);

        // Reset released mid left word.
        send_chunk(1'b0, 16, 16'h1111, 1'b0, 0);
        send_chunk(1'b1, 16, 16'h2222, 1'b0, 7);
        send_chunk(1'b0, 16, 16'h3333, 1'b0, 0);
        send_chunk(1'b1, 16, 16'h4444, 1'b0, 0);
        send_chunk(1'b0, 16, 16'h5555, 1'b0, 0);

        // Randomised slots: lengths, data, coincidences, short words, clears.
        lr = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (k < 58 && ($urandom % 8) == 0) nb = 1 + int'($urandom % 15);
            else                               nb = 16 + int'($urandom % 17);
            send_chunk(lr, nb, 16'($urandom), 1'(($urandom % 4) == 0), 0);
            if (($urandom % 5) == 0) pulse_clr();
            lr = ~lr;
        end
        pulse_clr();

        // Loopback ramp: alternating left/right samples back to back.
        if (m_lr) send_chunk(1'b0, 16, 16'h0000, 1'b0, 0);
        for (int f = 0; f < 120; f++) begin
            l_w = 16'(f * 16'h0123);
            send_chunk(1'b1, 16, l_w, 1'b0, 0);
            send_chunk(1'b0, 16, ~l_w, 1'b0, 0);
        end
        check("loopback_short_err", 32'(short_err), 32'h0);

        // Drain scoreboard with a bounded wait.
        for (int t = 0; t < 200 && sb_q.size() != 0; t++) #10;
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
